// File: rtl/edge_pkg.sv
// Shared types and helpers for the polygon edge walker.
// The vertex-index wrap rule lives here so the walker and its neighbours agree on it.
package edge_pkg;

  localparam int COO_EDGES_DEF = 6;
  localparam int CRD_BW_DEF    = 10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    SETUP  = 3'd3,
    STEP   = 3'd4,
    DONE   = 3'd5
  } walk_state_t;

  typedef struct packed {
    logic [CRD_BW_DEF-1:0] x;
    logic [CRD_BW_DEF-1:0] y;
  } coord_t;

  // Index of the far vertex of edge idx; the last edge closes back to vertex 0.
  function automatic int unsigned next_vtx(input int unsigned idx, input int unsigned edges);
    if (idx + 32'd1 >= edges) begin
      return 32'd0;
    end else begin
      return idx + 32'd1;
    end
  endfunction

endpackage

// File: rtl/bresenham_step.sv
// One combinational Bresenham advance: next pixel position and error term.
// Both axis updates are evaluated against the incoming error.
module bresenham_step
  import edge_pkg::*;
#(
  parameter int CRD_BW = CRD_BW_DEF
) (
  input  logic [CRD_BW-1:0]        cur_x,
  input  logic [CRD_BW-1:0]        cur_y,
  input  logic signed [CRD_BW+1:0] err,
  input  logic signed [CRD_BW:0]   dx,
  input  logic signed [CRD_BW:0]   dy,
  input  logic                     sx_neg,
  input  logic                     sy_neg,
  output logic [CRD_BW-1:0]        nxt_x,
  output logic [CRD_BW-1:0]        nxt_y,
  output logic signed [CRD_BW+1:0] nxt_err
);

  logic signed [CRD_BW+1:0] e2_s;
  logic signed [CRD_BW+1:0] dx_w_s;
  logic signed [CRD_BW+1:0] dy_w_s;
  logic                     step_x_s;
  logic                     step_y_s;

  // Decide which axes move and accumulate the matching error deltas.
  always_comb begin
    e2_s     = err <<< 1;
    dx_w_s   = {dx[CRD_BW], dx};
    dy_w_s   = {dy[CRD_BW], dy};
    step_x_s = (e2_s >= dy_w_s);
    step_y_s = (e2_s <= dx_w_s);
    nxt_err  = err;
    nxt_x    = cur_x;
    nxt_y    = cur_y;
    if (step_x_s) begin
      nxt_err = nxt_err + dy_w_s;
      if (sx_neg) begin
        nxt_x = cur_x - CRD_BW'(1);
      end else begin
        nxt_x = cur_x + CRD_BW'(1);
      end
    end else begin
      nxt_x = cur_x;
    end
    if (step_y_s) begin
      nxt_err = nxt_err + dx_w_s;
      if (sy_neg) begin
        nxt_y = cur_y - CRD_BW'(1);
      end else begin
        nxt_y = cur_y + CRD_BW'(1);
      end
    end else begin
      nxt_y = cur_y;
    end
  end

endmodule

// File: rtl/edge_walker.sv
// Rasterises one polygon edge (vertex[idx] -> vertex[idx+1]) and streams its pixels,
// then pulses edge_done so the edge counter advances to the next edge.
module edge_walker
  import edge_pkg::*;
#(
  parameter int COO_EDGES = COO_EDGES_DEF,
  parameter int COO_BW    = $clog2(COO_EDGES),
  parameter int CRD_BW    = CRD_BW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [COO_BW-1:0] edge_idx,
  output logic [COO_BW-1:0] vtx_addr,
  input  logic [CRD_BW-1:0] vtx_x,
  input  logic [CRD_BW-1:0] vtx_y,
  output logic [CRD_BW-1:0] pix_x,
  output logic [CRD_BW-1:0] pix_y,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              busy,
  output logic              edge_done
);

  walk_state_t              state_r;
  walk_state_t              state_nx_s;
  logic [COO_BW-1:0]        idx_r;
  logic [COO_BW-1:0]        vtx_addr_s;
  logic [CRD_BW-1:0]        x0_r, y0_r, x1_r, y1_r;
  logic [CRD_BW-1:0]        cur_x_r, cur_y_r;
  logic [CRD_BW-1:0]        nx_x_s, nx_y_s;
  logic signed [CRD_BW:0]   dx_r, dy_r, dx_s, dy_s;
  logic signed [CRD_BW+1:0] err_r, err0_s, nx_err_s;
  logic                     sx_neg_r, sy_neg_r, sx_neg_s, sy_neg_s;
  logic                     pix_valid_r, busy_r, edge_done_r;
  logic                     fire_s, at_end_s;

  assign fire_s   = pix_valid_r & pix_ready;
  assign at_end_s = (cur_x_r == x1_r) && (cur_y_r == y1_r);

  // Next-state logic; a stalled STEP simply holds.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nx_s = LOAD_A;
        end else begin
          state_nx_s = IDLE;
        end
      end
      LOAD_A: state_nx_s = LOAD_B;
      LOAD_B: state_nx_s = SETUP;
      SETUP:  state_nx_s = STEP;
      STEP: begin
        if (fire_s && at_end_s) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = STEP;
        end
      end
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Vertex read address: far endpoint only while loading B.
  always_comb begin
    vtx_addr_s = idx_r;
    if (state_r == LOAD_B) begin
      vtx_addr_s = COO_BW'(next_vtx(32'(idx_r), COO_EDGES));
    end else begin
      vtx_addr_s = idx_r;
    end
  end

  assign vtx_addr = vtx_addr_s;

  // Setup terms: dx >= 0, dy <= 0, and step directions from the endpoint order.
  always_comb begin
    dx_s     = {(CRD_BW+1){1'b0}};
    dy_s     = {(CRD_BW+1){1'b0}};
    sx_neg_s = 1'b0;
    sy_neg_s = 1'b0;
    if (x0_r < x1_r) begin
      dx_s     = $signed({1'b0, x1_r - x0_r});
      sx_neg_s = 1'b0;
    end else begin
      dx_s     = $signed({1'b0, x0_r - x1_r});
      sx_neg_s = 1'b1;
    end
    if (y0_r < y1_r) begin
      dy_s     = -$signed({1'b0, y1_r - y0_r});
      sy_neg_s = 1'b0;
    end else begin
      dy_s     = -$signed({1'b0, y0_r - y1_r});
      sy_neg_s = 1'b1;
    end
    err0_s = {dx_s[CRD_BW], dx_s} + {dy_s[CRD_BW], dy_s};
  end

  bresenham_step #(.CRD_BW(CRD_BW)) u_step (
    .cur_x   (cur_x_r),
    .cur_y   (cur_y_r),
    .err     (err_r),
    .dx      (dx_r),
    .dy      (dy_r),
    .sx_neg  (sx_neg_r),
    .sy_neg  (sy_neg_r),
    .nxt_x   (nx_x_s),
    .nxt_y   (nx_y_s),
    .nxt_err (nx_err_s)
  );

  // State, walk registers and registered handshake/status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      idx_r       <= {COO_BW{1'b0}};
      x0_r        <= {CRD_BW{1'b0}};
      y0_r        <= {CRD_BW{1'b0}};
      x1_r        <= {CRD_BW{1'b0}};
      y1_r        <= {CRD_BW{1'b0}};
      cur_x_r     <= {CRD_BW{1'b0}};
      cur_y_r     <= {CRD_BW{1'b0}};
      dx_r        <= {(CRD_BW+1){1'b0}};
      dy_r        <= {(CRD_BW+1){1'b0}};
      err_r       <= {(CRD_BW+2){1'b0}};
      sx_neg_r    <= 1'b0;
      sy_neg_r    <= 1'b0;
      pix_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      edge_done_r <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      pix_valid_r <= (state_nx_s == STEP);
      busy_r      <= (state_nx_s != IDLE);
      edge_done_r <= (state_nx_s == DONE);
      case (state_r)
        IDLE: begin
          if (start) begin
            idx_r <= edge_idx;
          end
        end
        LOAD_A: begin
          x0_r <= vtx_x;
          y0_r <= vtx_y;
        end
        LOAD_B: begin
          x1_r <= vtx_x;
          y1_r <= vtx_y;
        end
        SETUP: begin
          dx_r     <= dx_s;
          dy_r     <= dy_s;
          sx_neg_r <= sx_neg_s;
          sy_neg_r <= sy_neg_s;
          err_r    <= err0_s;
          cur_x_r  <= x0_r;
          cur_y_r  <= y0_r;
        end
        STEP: begin
          if (fire_s && !at_end_s) begin
            cur_x_r <= nx_x_s;
            cur_y_r <= nx_y_s;
            err_r   <= nx_err_s;
          end
        end
        DONE: begin
          idx_r <= idx_r;
        end
        default: begin
          idx_r <= idx_r;
        end
      endcase
    end
  end

  assign pix_x     = cur_x_r;
  assign pix_y     = cur_y_r;
  assign pix_valid = pix_valid_r;
  assign busy      = busy_r;
  assign edge_done = edge_done_r;

endmodule

// File: tb/tb_edge_walker.sv
// Randomised bench for edge_walker with a mod-N edge counter closing the loop on edge_done.
// Expected pixels come from a plain textbook Bresenham line walk.
module tb_edge_walker;
  import edge_pkg::*;

  localparam int NE = COO_EDGES_DEF;
  localparam int CB = CRD_BW_DEF;
  localparam int AB = $clog2(NE);

  logic          clk = 1'b0;
  logic          reset, start, pix_ready;
  logic          pix_valid, busy, edge_done;
  logic [AB-1:0] edge_idx, vtx_addr, cnt;
  logic [CB-1:0] vtx_x, vtx_y, pix_x, pix_y;
  coord_t        vtab [NE];
  int            ai;
  int            total = 0;
  int            bad = 0;
  int            exp_x[$], exp_y[$], got_x[$], got_y[$], idx_seq[$];

  always #5 clk = ~clk;

  edge_walker dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .edge_idx  (edge_idx),
    .vtx_addr  (vtx_addr),
    .vtx_x     (vtx_x),
    .vtx_y     (vtx_y),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .busy      (busy),
    .edge_done (edge_done)
  );

  assign edge_idx = cnt;

  always_comb begin
    ai    = int'(vtx_addr);
    vtx_x = {CB{1'b0}};
    vtx_y = {CB{1'b0}};
    if (ai < NE) begin
      vtx_x = vtab[ai].x;
      vtx_y = vtab[ai].y;
    end
  end

  // Stand-in for the downstream edge counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt <= AB'(0);
    else if (edge_done) cnt <= (int'(cnt) == NE - 1) ? AB'(0) : cnt + AB'(1);
  end

  task automatic check_val(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void build_expected(input int x0, input int y0, input int x1, input int y1);
    int dx, dy, sx, sy, err, e2, x, y;
    exp_x.delete();
    exp_y.delete();
    dx  = (x1 > x0) ? x1 - x0 : x0 - x1;
    dy  = -((y1 > y0) ? y1 - y0 : y0 - y1);
    sx  = (x0 < x1) ? 1 : -1;
    sy  = (y0 < y1) ? 1 : -1;
    err = dx + dy;
    x   = x0;
    y   = y0;
    for (int n = 0; n < 4096; n++) begin
      exp_x.push_back(x);
      exp_y.push_back(y);
      if (x == x1 && y == y1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endfunction

  task automatic set_vtx(input int i, input int x, input int y);
    vtab[i].x = CB'(x);
    vtab[i].y = CB'(y);
  endtask

  // mode 0: always ready, 1: random ready, 2: three-cycle stall on the second pixel
  task automatic run_walk(input int mode, input bit pulse_start, input bit timing_chk);
    int a, b, c, first_c, done_c, stalls, mdx, mdy;
    bit prev_stall, r, busy_ok;
    logic [CB-1:0] px, py;
    a = int'(cnt);
    b = (a == NE - 1) ? 0 : a + 1;
    idx_seq.push_back(a);
    build_expected(int'(vtab[a].x), int'(vtab[a].y), int'(vtab[b].x), int'(vtab[b].y));
    mdx = (vtab[a].x > vtab[b].x) ? int'(vtab[a].x) - int'(vtab[b].x) : int'(vtab[b].x) - int'(vtab[a].x);
    mdy = (vtab[a].y > vtab[b].y) ? int'(vtab[a].y) - int'(vtab[b].y) : int'(vtab[b].y) - int'(vtab[a].y);
    got_x.delete();
    got_y.delete();
    first_c = -1; done_c = -1; stalls = 0; prev_stall = 1'b0; busy_ok = 1'b1;
    px = '0; py = '0;
    @(negedge clk);
    start = 1'b1;
    c = 0;
    while (c < 5000) begin
      @(negedge clk);
      c++;
      if (c == 1) check_val("addr_a", int'(vtx_addr), a);
      if (c == 2) check_val("addr_b", int'(vtx_addr), b);
      if (prev_stall) begin
        check_val("hold_valid", int'(pix_valid), 1);
        check_val("hold_x", int'(pix_x), int'(px));
        check_val("hold_y", int'(pix_y), int'(py));
      end
      busy_ok &= busy;
      case (mode)
        0: r = 1'b1;
        1: r = ($urandom_range(0, 3) != 0);
        default: begin
          r = 1'b1;
          if (pix_valid && got_x.size() == 1 && stalls < 3) begin
            r = 1'b0;
            stalls++;
          end
        end
      endcase
      pix_ready = r;
      start = pulse_start && (c == 4);
      if (pix_valid && r) begin
        got_x.push_back(int'(pix_x));
        got_y.push_back(int'(pix_y));
        if (first_c < 0) first_c = c;
      end
      prev_stall = pix_valid && !r;
      px = pix_x;
      py = pix_y;
      if (edge_done) begin
        done_c = c;
        check_val("valid_in_done", int'(pix_valid), 0);
        break;
      end
    end
    check_val("done_seen", int'(done_c >= 0), 1);
    check_val("busy_walk", int'(busy_ok), 1);
    @(negedge clk);
    start = 1'b0;
    check_val("busy_after", int'(busy), 0);
    check_val("done_pulse", int'(edge_done), 0);
    @(negedge clk);
    check_val("no_restart", int'(busy), 0);
    check_val("npix", got_x.size(), ((mdx > mdy) ? mdx : mdy) + 1);
    for (int i = 0; i < exp_x.size() && i < got_x.size(); i++)
      check_val($sformatf("pix%0d", i), got_x[i] * 65536 + got_y[i], exp_x[i] * 65536 + exp_y[i]);
    if (timing_chk) begin
      check_val("first_cycle", first_c, 4);
      check_val("done_cycle", done_c, 4 + exp_x.size());
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int sel;
    bit seen;
    reset = 1'b1;
    start = 1'b0;
    pix_ready = 1'b0;
    for (int i = 0; i < NE; i++) set_vtx(i, 0, 0);
    #12;
    check_val("rst_valid", int'(pix_valid), 0);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_done", int'(edge_done), 0);
    check_val("rst_x", int'(pix_x), 0);
    check_val("rst_y", int'(pix_y), 0);
    @(negedge clk);
    reset = 1'b0;

    // Directed edges 0..5, then a random edge 0 to close the counter loop.
    idx_seq.delete();
    set_vtx(0, 0, 0);  set_vtx(1, 3, 0);
    run_walk(0, 1'b0, 1'b1);
    check_val("horiz_last", got_x.size() == 4 ? got_x[3] : -1, 3);
    set_vtx(1, 0, 0);  set_vtx(2, 1, 3);
    run_walk(0, 1'b0, 1'b1);
    check_val("steep_p1", got_x.size() == 4 ? got_x[1] * 16 + got_y[1] : -1, 0 * 16 + 1);
    check_val("steep_p2", got_x.size() == 4 ? got_x[2] * 16 + got_y[2] : -1, 1 * 16 + 2);
    set_vtx(2, 3, 3);  set_vtx(3, 0, 0);
    run_walk(0, 1'b0, 1'b1);
    check_val("rev_p1", got_x.size() == 4 ? got_x[1] * 16 + got_y[1] : -1, 2 * 16 + 2);
    set_vtx(3, 5, 5);  set_vtx(4, 5, 5);
    run_walk(0, 1'b1, 1'b1);
    check_val("degen_pix", got_x.size() == 1 ? got_x[0] * 16 + got_y[0] : -1, 5 * 16 + 5);
    set_vtx(4, 7, 2);  set_vtx(5, 1, 6);
    run_walk(2, 1'b0, 1'b0);
    set_vtx(5, 10, 10); set_vtx(0, 10, 12);
    run_walk(0, 1'b0, 1'b1);
    set_vtx(0, $urandom_range(0, 63), $urandom_range(0, 63));
    set_vtx(1, $urandom_range(0, 63), $urandom_range(0, 63));
    run_walk(1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++)
      check_val($sformatf("seq%0d", i), (i < idx_seq.size()) ? idx_seq[i] : -1, i % NE);

    // Random edges under random backpressure.
    for (int n = 0; n < 12; n++) begin
      sel = int'(cnt);
      for (int k = 0; k < 2; k++) begin
        if (n < 6) set_vtx((sel + k) % NE, $urandom_range(0, 63), $urandom_range(0, 63));
        else       set_vtx((sel + k) % NE, $urandom_range(0, 1023), $urandom_range(0, 1023));
      end
      run_walk(1, 1'b0, 1'b0);
    end

    // Asynchronous reset in the middle of a walk.
    sel = int'(cnt);
    set_vtx(sel, 100, 100);
    set_vtx((sel + 1) % NE, 200, 150);
    @(negedge clk);
    start = 1'b1;
    pix_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check_val("pre_rst_valid", int'(pix_valid), 1);
    #2 reset = 1'b1;
    #1;
    check_val("mid_rst_valid", int'(pix_valid), 0);
    check_val("mid_rst_x", int'(pix_x), 0);
    check_val("mid_rst_y", int'(pix_y), 0);
    check_val("mid_rst_busy", int'(busy), 0);
    check_val("mid_rst_done", int'(edge_done), 0);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen |= pix_valid | edge_done | busy;
    end
    check_val("post_rst_quiet", int'(seen), 0);
    check_val("post_rst_cnt", int'(cnt), 0);
    set_vtx(0, $urandom_range(0, 63), $urandom_range(0, 63));
    set_vtx(1, $urandom_range(0, 63), $urandom_range(0, 63));
    run_walk(1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
